// File: rtl/mem_stage_if.sv
// rtl/mem_stage_if.sv - EX/MEM/WB handshake and data-SRAM response bundle for mem_stage
interface mem_stage_if;
  logic        MEM_allowin;
  logic        EX_MEM_valid;
  logic [76:0] EX_MEM_bus;
  logic [85:0] EX_except_bus;
  logic [85:0] MEM_except_bus;
  logic        MEM_EXC_signal;
  logic        WB_EXC_signal;
  logic        WB_allowin;
  logic        MEM_WB_valid;
  logic [69:0] MEM_WB_bus;
  logic [38:0] MEM_rf_bus;
  logic        data_sram_data_ok;
  logic [31:0] data_sram_rdata;

  modport slave (
    input  EX_MEM_valid, EX_MEM_bus, EX_except_bus, WB_EXC_signal, WB_allowin,
           data_sram_data_ok, data_sram_rdata,
    output MEM_allowin, MEM_except_bus, MEM_EXC_signal, MEM_WB_valid, MEM_WB_bus, MEM_rf_bus
  );

  modport master (
    output EX_MEM_valid, EX_MEM_bus, EX_except_bus, WB_EXC_signal, WB_allowin,
           data_sram_data_ok, data_sram_rdata,
    input  MEM_allowin, MEM_except_bus, MEM_EXC_signal, MEM_WB_valid, MEM_WB_bus, MEM_rf_bus
  );
endinterface

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - pipeline MEM stage with data-SRAM response tracking; optional MEM_LD_FWD_EN
module mem_stage (
  input  logic       clk,
  input  logic       resetn,
  mem_stage_if.slave mif
);

  typedef enum logic [1:0] {IDLE, WAIT, HOLD, DROP} req_state_t;

  req_state_t  state, state_nxt;
  logic        mem_valid;
  logic [76:0] payload;
  logic [85:0] except_r;
  logic [31:0] rdata_buf;

  logic        data_ok, flush, ready_go, allowin, accept, accept_req, handoff, exc;

  logic [31:0] pc, alu_result;
  logic        rf_we, res_from_mem, req_made;
  logic [4:0]  rf_waddr;
  logic        ld_w, ld_b, ld_h, ld_bu, ld_hu;

  logic [31:0] ld_word, ld_ext, final_result;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic        rf_we_out, ld_pending;

  assign pc           = payload[76:45];
  assign alu_result   = payload[44:13];
  assign rf_we        = payload[12];
  assign rf_waddr     = payload[11:7];
  assign res_from_mem = payload[6];
  assign ld_w         = payload[5];
  assign ld_b         = payload[4];
  assign ld_h         = payload[3];
  assign ld_bu        = payload[2];
  assign ld_hu        = payload[1];
  assign req_made     = payload[0];

  assign data_ok    = mif.data_sram_data_ok;
  assign flush      = mif.WB_EXC_signal;
  assign ready_go   = (state == IDLE) | (state == HOLD) | ((state == WAIT) & data_ok);
  // DROP still owes a response that must be absorbed before anything new enters
  assign allowin    = (state != DROP) & (~mem_valid | (ready_go & mif.WB_allowin));
  assign accept     = mif.EX_MEM_valid & allowin;
  assign accept_req = accept & mif.EX_MEM_bus[0];
  assign handoff    = mem_valid & ready_go & mif.WB_allowin;

  // Next request-tracking state; a handoff may coincide with a new request entering
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (accept_req) state_nxt = flush ? DROP : WAIT;
      WAIT: begin
        if (data_ok) begin
          if (handoff)     state_nxt = accept_req ? (flush ? DROP : WAIT) : IDLE;
          else             state_nxt = flush ? IDLE : HOLD;
        end else if (flush) begin
          state_nxt = DROP;
        end
      end
      HOLD: begin
        if (handoff)       state_nxt = accept_req ? (flush ? DROP : WAIT) : IDLE;
        else if (flush)    state_nxt = IDLE;
      end
      DROP: if (data_ok) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Request-tracking state register; reset abandons any owed response
  always_ff @(posedge clk) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  // Instruction slot: valid bit, payload and exception flags
  always_ff @(posedge clk) begin
    if (!resetn) begin
      mem_valid <= 1'b0;
      payload   <= '0;
      except_r  <= '0;
    end else begin
      if (flush)        mem_valid <= 1'b0;
      else if (allowin) mem_valid <= mif.EX_MEM_valid;
      if (accept) begin
        payload  <= mif.EX_MEM_bus;
        except_r <= mif.EX_except_bus;
      end
    end
  end

  // Keep the response when WB is stalled so the SRAM bus can move on
  always_ff @(posedge clk) begin
    if (!resetn)
      rdata_buf <= '0;
    else if ((state == WAIT) & data_ok & ~mif.WB_allowin & req_made)
      rdata_buf <= mif.data_sram_rdata;
  end

  // Lane selection and sign/zero extension of load data
  always_comb begin
    ld_word = (state == HOLD) ? rdata_buf : mif.data_sram_rdata;
    case (alu_result[1:0])
      2'd0:    ld_byte = ld_word[7:0];
      2'd1:    ld_byte = ld_word[15:8];
      2'd2:    ld_byte = ld_word[23:16];
      default: ld_byte = ld_word[31:24];
    endcase
    ld_half = alu_result[1] ? ld_word[31:16] : ld_word[15:0];
    ld_ext  = ld_word;
    if (ld_w)       ld_ext = ld_word;
    else if (ld_b)  ld_ext = {{24{ld_byte[7]}}, ld_byte};
    else if (ld_bu) ld_ext = {24'd0, ld_byte};
    else if (ld_h)  ld_ext = {{16{ld_half[15]}}, ld_half};
    else if (ld_hu) ld_ext = {16'd0, ld_half};
  end

  assign final_result = res_from_mem ? ld_ext : alu_result;
  assign exc          = |except_r;
  assign rf_we_out    = rf_we & ~exc;

`ifdef MEM_LD_FWD_EN
  assign ld_pending = mem_valid & res_from_mem & ~ready_go;
`else
  assign ld_pending = mem_valid & res_from_mem;
`endif

  assign mif.MEM_allowin    = allowin;
  assign mif.MEM_WB_valid   = mem_valid & ready_go;
  assign mif.MEM_WB_bus     = {pc, rf_we_out, rf_waddr, final_result};
  assign mif.MEM_rf_bus     = {ld_pending, rf_we_out & mem_valid, rf_waddr, final_result};
  assign mif.MEM_except_bus = except_r;
  assign mif.MEM_EXC_signal = mem_valid & exc;

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - scoreboard bench for mem_stage
`timescale 1ns/1ps
module tb_mem_stage;
  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  mem_stage_if mif();
  mem_stage dut (.clk(clk), .resetn(resetn), .mif(mif));

`ifdef MEM_LD_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  typedef struct {
    logic [69:0] wb;
    logic [85:0] exc;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   n_handoff = 0;

  // byte/half extraction by shifting and two's-complement arithmetic
  function automatic logic [31:0] load_ref(input logic [4:0] ld, input logic [31:0] addr,
                                           input logic [31:0] word);
    int v;
    int boff;
    int hoff;
    boff = int'(addr[1:0]) * 8;
    hoff = int'(addr[1]) * 16;
    if (ld[3] || ld[1]) begin
      v = int'((word >> boff) & 32'hFF);
      if (ld[3] && v >= 128) v -= 256;
    end else if (ld[2] || ld[0]) begin
      v = int'((word >> hoff) & 32'hFFFF);
      if (ld[2] && v >= 32768) v -= 65536;
    end else begin
      v = int'(word);
    end
    return 32'(v);
  endfunction

  function automatic logic [76:0] mk_bus(input logic [31:0] pc, input logic [31:0] alu,
                                         input logic we, input logic [4:0] wa, input logic res,
                                         input logic [4:0] ld, input logic req);
    return {pc, alu, we, wa, res, ld, req};
  endfunction

  task automatic push_exp(input logic [76:0] b, input logic [85:0] exc, input logic [31:0] rd);
    exp_t e;
    logic [31:0] alu;
    logic [31:0] res;
    alu   = b[44:13];
    res   = b[6] ? load_ref(b[5:1], alu, rd) : alu;
    e.wb  = {b[76:45], b[12] & (exc == '0), b[11:7], res};
    e.exc = exc;
    exp_q.push_back(e);
  endtask

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  task automatic idle_inputs();
    mif.EX_MEM_valid      = 1'b0;
    mif.WB_EXC_signal     = 1'b0;
    mif.WB_allowin        = 1'b1;
    mif.data_sram_data_ok = 1'b0;
    mif.data_sram_rdata   = $urandom;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every MEM->WB handoff is checked against the oldest expected entry
  always @(negedge clk) begin : monitor
    exp_t e;
    if (resetn && mif.MEM_WB_valid && mif.WB_allowin) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL handoff_unexpected: got bus %h want no handoff", mif.MEM_WB_bus);
      end else begin
        e = exp_q.pop_front();
        n_handoff++;
        if (mif.MEM_WB_bus !== e.wb || mif.MEM_except_bus !== e.exc) begin
          n_fail++;
          $display("FAIL handoff_data: got bus %h exc %h want bus %h exc %h",
                   mif.MEM_WB_bus, mif.MEM_except_bus, e.wb, e.exc);
        end
      end
    end
  end

  logic [76:0] b;
  logic [85:0] x;
  logic [31:0] rd;
  logic        flush;
  logic        owed;
  int          delay;
  logic [31:0] resp;

  initial begin
    resetn = 1'b0;
    idle_inputs();
    mif.EX_MEM_bus    = '0;
    mif.EX_except_bus = '0;
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
    @(negedge clk);
    check("rst_wb_valid", mif.MEM_WB_valid, 0);
    check("rst_allowin", mif.MEM_allowin, 1);
    check("rst_exc", mif.MEM_EXC_signal, 0);
    check("rst_rf_bus", mif.MEM_rf_bus, 0);
    check("rst_wb_bus", mif.MEM_WB_bus, 0);
    check("rst_except", mif.MEM_except_bus, 0);

    // ALU instruction: one cycle in MEM, bypass bus shows the write
    next_cycle(); idle_inputs();
    b = mk_bus(32'h100, 32'h1234, 1'b1, 5'd5, 1'b0, 5'b0, 1'b0);
    mif.EX_MEM_valid = 1'b1; mif.EX_MEM_bus = b; mif.EX_except_bus = '0;
    @(negedge clk); check("alu_accept", mif.MEM_allowin, 1); push_exp(b, '0, 32'h0);
    next_cycle(); idle_inputs();
    @(negedge clk);
    check("alu_wb_valid", mif.MEM_WB_valid, 1);
    check("alu_rf_bus", mif.MEM_rf_bus, {1'b0, 1'b1, 5'd5, 32'h1234});

    // exception flags suppress the register write but pass through
    next_cycle(); idle_inputs();
    b = mk_bus(32'h200, 32'hABCD, 1'b1, 5'd7, 1'b0, 5'b0, 1'b0);
    x = 86'h40;
    mif.EX_MEM_valid = 1'b1; mif.EX_MEM_bus = b; mif.EX_except_bus = x;
    @(negedge clk); push_exp(b, x, 32'h0);
    next_cycle(); idle_inputs(); mif.EX_except_bus = '0;
    @(negedge clk);
    check("exc_signal", mif.MEM_EXC_signal, 1);
    check("exc_rf_we_rf", mif.MEM_rf_bus[37], 0);
    check("exc_rf_we_wb", mif.MEM_WB_bus[37], 0);
    check("exc_bus_fwd", mif.MEM_except_bus, 86'h40);

    // ld_b at byte 3, response in the cycle after accept
    next_cycle(); idle_inputs();
    b = mk_bus(32'h300, 32'h1003, 1'b1, 5'd9, 1'b1, 5'b01000, 1'b1);
    mif.EX_MEM_valid = 1'b1; mif.EX_MEM_bus = b;
    @(negedge clk); check("ldb_accept", mif.MEM_allowin, 1); push_exp(b, '0, 32'h80FF_1234);
    next_cycle(); idle_inputs();
    mif.data_sram_data_ok = 1'b1; mif.data_sram_rdata = 32'h80FF_1234;
    @(negedge clk);
    check("ldb_wb_valid", mif.MEM_WB_valid, 1);
    check("ldb_result", mif.MEM_WB_bus[31:0], 32'hFFFF_FF80);

    // ld_hu with WB stalled across the response: buffered data, ld_pending behaviour
    next_cycle(); idle_inputs();
    b = mk_bus(32'h400, 32'h2002, 1'b1, 5'd10, 1'b1, 5'b00001, 1'b1);
    mif.EX_MEM_valid = 1'b1; mif.EX_MEM_bus = b;
    @(negedge clk); push_exp(b, '0, 32'h9ABC_0000);
    next_cycle(); idle_inputs(); mif.WB_allowin = 1'b0;
    @(negedge clk);
    check("hu_wait_valid", mif.MEM_WB_valid, 0);
    check("hu_wait_allowin", mif.MEM_allowin, 0);
    check("hu_wait_pending", mif.MEM_rf_bus[38], 1);
    next_cycle(); idle_inputs(); mif.WB_allowin = 1'b0;
    mif.data_sram_data_ok = 1'b1; mif.data_sram_rdata = 32'h9ABC_0000;
    @(negedge clk);
    check("hu_dok_valid", mif.MEM_WB_valid, 1);
    check("hu_dok_pending", mif.MEM_rf_bus[38], FWD ? 1'b0 : 1'b1);
    next_cycle(); idle_inputs(); mif.WB_allowin = 1'b0; mif.data_sram_rdata = 32'h5555_AAAA;
    @(negedge clk);
    check("hu_hold_valid", mif.MEM_WB_valid, 1);
    check("hu_hold_result", mif.MEM_WB_bus[31:0], 32'h0000_9ABC);
    check("hu_hold_pending", mif.MEM_rf_bus[38], FWD ? 1'b0 : 1'b1);
    next_cycle(); idle_inputs(); mif.data_sram_rdata = 32'h1111_2222;
    @(negedge clk);
    check("hu_release_valid", mif.MEM_WB_valid, 1);
    check("hu_release_result", mif.MEM_WB_bus[31:0], 32'h0000_9ABC);
    next_cycle(); idle_inputs();
    @(negedge clk);
    check("hu_after_valid", mif.MEM_WB_valid, 0);
    check("hu_after_allowin", mif.MEM_allowin, 1);

    // flush while waiting: response owed, nothing accepted until it arrives
    next_cycle(); idle_inputs();
    b = mk_bus(32'h600, 32'h3000, 1'b1, 5'd3, 1'b1, 5'b10000, 1'b1);
    mif.EX_MEM_valid = 1'b1; mif.EX_MEM_bus = b;
    @(negedge clk); push_exp(b, '0, 32'h0);
    next_cycle(); idle_inputs(); mif.WB_EXC_signal = 1'b1;
    @(negedge clk);
    check("drop_flush_valid", mif.MEM_WB_valid, 0);
    if (exp_q.size() > 0) void'(exp_q.pop_back());
    next_cycle(); idle_inputs();
    mif.EX_MEM_valid = 1'b1; mif.EX_MEM_bus = mk_bus(32'h640, 32'h77, 1'b1, 5'd4, 1'b0, 5'b0, 1'b0);
    @(negedge clk);
    check("drop_allowin", mif.MEM_allowin, 0);
    check("drop_valid", mif.MEM_WB_valid, 0);
    check("drop_exc", mif.MEM_EXC_signal, 0);
    next_cycle(); mif.data_sram_data_ok = 1'b1;
    @(negedge clk);
    check("drop_dok_allowin", mif.MEM_allowin, 0);
    check("drop_dok_valid", mif.MEM_WB_valid, 0);
    next_cycle(); idle_inputs();
    @(negedge clk);
    check("drop_end_allowin", mif.MEM_allowin, 1);
    check("drop_end_valid", mif.MEM_WB_valid, 0);

    // reset while waiting: no DROP, a stale response in IDLE is ignored
    next_cycle(); idle_inputs();
    b = mk_bus(32'h700, 32'h4000, 1'b1, 5'd6, 1'b1, 5'b10000, 1'b1);
    mif.EX_MEM_valid = 1'b1; mif.EX_MEM_bus = b;
    @(negedge clk); push_exp(b, '0, 32'h0);
    next_cycle(); idle_inputs(); resetn = 1'b0;
    @(negedge clk); exp_q.delete();
    next_cycle(); resetn = 1'b1;
    @(negedge clk);
    check("rstw_allowin", mif.MEM_allowin, 1);
    check("rstw_valid", mif.MEM_WB_valid, 0);
    next_cycle(); mif.data_sram_data_ok = 1'b1;
    @(negedge clk);
    check("stale_allowin", mif.MEM_allowin, 1);
    check("stale_valid", mif.MEM_WB_valid, 0);
    next_cycle(); idle_inputs();
    b = mk_bus(32'h800, 32'hBEEF, 1'b1, 5'd8, 1'b0, 5'b0, 1'b0);
    mif.EX_MEM_valid = 1'b1; mif.EX_MEM_bus = b;
    @(negedge clk); push_exp(b, '0, 32'h0);
    next_cycle(); idle_inputs();
    @(negedge clk);
    check("post_rst_valid", mif.MEM_WB_valid, 1);

    // randomized traffic with an in-order memory model and occasional flushes
    owed  = 1'b0;
    delay = 0;
    resp  = '0;
    for (int c = 0; c < 3000; c++) begin
      next_cycle();
      mif.data_sram_data_ok = owed && (delay == 0);
      mif.data_sram_rdata   = mif.data_sram_data_ok ? resp : $urandom;
      flush = (c < 2900) && ($urandom_range(0, 19) == 0);
      mif.WB_EXC_signal = flush;
      if (flush) begin
        mif.EX_MEM_valid = 1'b0;
        mif.WB_allowin   = 1'b0;
      end else begin
        mif.EX_MEM_valid = (c < 2900) && ($urandom_range(0, 3) != 0);
        mif.WB_allowin   = (c >= 2900) || ($urandom_range(0, 9) < 7);
        case ($urandom_range(0, 2))
          0: b = mk_bus($urandom, $urandom, 1'($urandom), 5'($urandom), 1'b0, 5'b0, 1'b0);
          1: b = mk_bus($urandom, $urandom, 1'($urandom), 5'($urandom), 1'b1,
                        5'(1 << $urandom_range(0, 4)), 1'b1);
          default: b = mk_bus($urandom, $urandom, 1'b0, 5'($urandom), 1'b0, 5'b0, 1'b1);
        endcase
        x = ($urandom_range(0, 7) == 0) ? (86'd1 << $urandom_range(0, 85)) : '0;
        mif.EX_MEM_bus    = b;
        mif.EX_except_bus = x;
      end
      rd = $urandom;
      @(negedge clk);
      if (mif.data_sram_data_ok) owed = 1'b0;
      else if (owed && delay > 0) delay--;
      if (flush && exp_q.size() > 0) void'(exp_q.pop_back());
      if (mif.EX_MEM_valid && mif.MEM_allowin) begin
        push_exp(b, x, rd);
        if (b[0]) begin
          owed  = 1'b1;
          delay = $urandom_range(0, 3);
          resp  = rd;
        end
      end
    end
    next_cycle(); idle_inputs();
    @(negedge clk);
    check("drain_empty", exp_q.size(), 0);
    check("handoff_count", n_handoff > 200, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
